// File: rtl/sync_pkg.sv
// Shared limits and helpers for the sync_filter_nff input synchroniser.
package sync_pkg;

   localparam int MIN_STAGES = 2;
   localparam int MIN_FILTER = 1;

   // A FILTER of 1 or 2 still needs one counter bit.
   function automatic int cnt_width(input int filter);
      return (filter <= 2) ? 1 : $clog2(filter);
   endfunction

endpackage

// File: rtl/sync_filter_bit.sv
// One input bit: synchroniser chain, persistence counter, filtered value and edge pulses.
module sync_filter_bit
   import sync_pkg::*;
#(
   parameter int   STAGES  = 2,
   parameter int   FILTER  = 4,
   parameter logic RST_BIT = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic ena,
   input  logic raw,
   output logic value,
   output logic rise,
   output logic fall,
   output logic accept
);

   localparam int CW = cnt_width(FILTER);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

   logic [STAGES-1:0] sync_p0;
   logic [CW-1:0]     cnt;
   logic              s;

   // Synchroniser stage: shifts regardless of ena so the chain never holds stale data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p0 <= {STAGES{RST_BIT}};
      end else begin
         sync_p0 <= {sync_p0[STAGES-2:0], raw};
      end
   end

   assign s      = sync_p0[STAGES-1];
   assign accept = ena && (s != value) && (cnt == CNT_LAST);

   // Filter stage: a difference must persist for FILTER consecutive enabled edges.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         value <= RST_BIT;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (!ena || (s == value)) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            value <= s;
            rise  <= s;
            fall  <= ~s;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/sync_filter_nff.sv
// Multi-bit boundary synchroniser with per-bit glitch filter and registered edge flags.
module sync_filter_nff
   import sync_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter int               STAGES  = 2,
   parameter int               FILTER  = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             changed
);

   if (STAGES < MIN_STAGES) begin : g_bad_stages
      $error("sync_filter_nff: STAGES must be at least %0d", MIN_STAGES);
   end
   if (FILTER < MIN_FILTER) begin : g_bad_filter
      $error("sync_filter_nff: FILTER must be at least %0d", MIN_FILTER);
   end

   logic [WIDTH-1:0] accept;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      sync_filter_bit #(
         .STAGES  (STAGES),
         .FILTER  (FILTER),
         .RST_BIT (RST_VAL[i])
      ) u_bit (
         .clk    (clk),
         .rst    (rst),
         .ena    (ena),
         .raw    (data_in[i]),
         .value  (data_out[i]),
         .rise   (rise[i]),
         .fall   (fall[i]),
         .accept (accept[i])
      );
   end

   // Registered from the per-bit acceptance so it lines up with rise/fall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         changed <= 1'b0;
      end else begin
         changed <= |accept;
      end
   end

endmodule

// File: tb/tb_sync_filter_nff.sv
// Directed bench for sync_filter_nff: window-based reference model plus literal checkpoints.
module tb_sync_filter_nff;

   localparam int LOG_N = 1024;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic [7:0] data_in;

   logic [7:0] out_a, rise_a, fall_a;
   logic       chg_a;
   logic [7:0] out_b, rise_b, fall_b;
   logic       chg_b;

   int passed = 0;
   int total  = 0;

   sync_filter_nff #(.WIDTH(8), .STAGES(2), .FILTER(3), .RST_VAL(8'h00)) dut_a (
      .clk(clk), .rst(rst), .ena(ena), .data_in(data_in),
      .data_out(out_a), .rise(rise_a), .fall(fall_a), .changed(chg_a)
   );

   sync_filter_nff #(.WIDTH(8), .STAGES(3), .FILTER(1), .RST_VAL(8'h00)) dut_b (
      .clk(clk), .rst(rst), .ena(ena), .data_in(data_in),
      .data_out(out_b), .rise(rise_b), .fall(fall_b), .changed(chg_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: log of sampled inputs since reset; a bit flips when the
   // synchronised value has differed from the output on the last FILTER enabled edges.
   logic [7:0] din_log [0:LOG_N-1];
   bit         ena_log [0:LOG_N-1];
   int         n = 0;

   logic [7:0] m_out_a = '0, m_rise_a = '0, m_fall_a = '0;
   logic       m_chg_a = 1'b0;
   logic [7:0] m_out_b = '0, m_rise_b = '0, m_fall_b = '0;
   logic       m_chg_b = 1'b0;

   function automatic logic [7:0] s_at(input int idx, input int st);
      if (idx >= st) return din_log[idx-st];
      return 8'h00;
   endfunction

   task automatic model_cfg(input int st, input int flt, inout logic [7:0] out,
                            output logic [7:0] r, output logic [7:0] f, output logic c);
      logic [7:0] acc;
      logic [7:0] sv;
      bit         ok;
      acc = '0;
      if (n >= flt - 1) begin
         for (int i = 0; i < 8; i++) begin
            ok = 1'b1;
            for (int k = 0; k < flt; k++) begin
               sv = s_at(n - k, st);
               if (!ena_log[n-k] || (sv[i] == out[i])) ok = 1'b0;
            end
            acc[i] = ok;
         end
      end
      out = out ^ acc;
      r   = acc & out;
      f   = acc & ~out;
      c   = |acc;
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            n = 0;
            m_out_a = '0; m_rise_a = '0; m_fall_a = '0; m_chg_a = 1'b0;
            m_out_b = '0; m_rise_b = '0; m_fall_b = '0; m_chg_b = 1'b0;
         end else if (n < LOG_N) begin
            din_log[n] = data_in;
            ena_log[n] = ena;
            model_cfg(2, 3, m_out_a, m_rise_a, m_fall_a, m_chg_a);
            model_cfg(3, 1, m_out_b, m_rise_b, m_fall_b, m_chg_b);
            n++;
         end
      end
   end

   always @(negedge clk) begin
      check("cmp_out_a",  out_a,  m_out_a);
      check("cmp_rise_a", rise_a, m_rise_a);
      check("cmp_fall_a", fall_a, m_fall_a);
      check("cmp_chg_a",  {7'd0, chg_a}, {7'd0, m_chg_a});
      check("cmp_out_b",  out_b,  m_out_b);
      check("cmp_rise_b", rise_b, m_rise_b);
      check("cmp_fall_b", fall_b, m_fall_b);
      check("cmp_chg_b",  {7'd0, chg_b}, {7'd0, m_chg_b});
   end

   int pulses;
   int rise_t, fall_t, rise_n, fall_n;

   initial begin
      rst = 1'b1; ena = 1'b0; data_in = 8'hAA;
      #3;
      check("rst_out_a",  out_a, 8'h00);
      check("rst_rise_a", rise_a, 8'h00);
      check("rst_fall_a", fall_a, 8'h00);
      check("rst_chg_a",  {7'd0, chg_a}, 8'h00);
      check("rst_out_b",  out_b, 8'h00);

      @(posedge clk); #1 rst = 1'b0;
      repeat (10) begin
         tick();
         check("ena0_out_a",   out_a, 8'h00);
         check("ena0_pulse_a", rise_a | fall_a, 8'h00);
      end

      // Flush the chains to zero so the next change starts from a known point.
      data_in = 8'h00;
      repeat (3) tick();

      ena = 1'b1; data_in = 8'hAA;
      repeat (3) tick();
      check("lat_b_early", out_b, 8'h00);
      tick();
      check("lat_out_a_e4", out_a, 8'h00);
      check("lat_out_b_e4", out_b, 8'hAA);
      check("lat_rise_b",   rise_b, 8'hAA);
      tick();
      check("lat_out_a", out_a, 8'hAA);
      check("lat_rise_a", rise_a, 8'hAA);
      check("lat_fall_a", fall_a, 8'h00);
      check("lat_chg_a", {7'd0, chg_a}, 8'h01);
      tick();
      check("lat_rise_a_gone", rise_a, 8'h00);
      check("lat_chg_a_gone", {7'd0, chg_a}, 8'h00);

      data_in = 8'hFF;
      repeat (4) tick();
      check("ff_out_a_e4", out_a, 8'hAA);
      check("ff_rise_b", rise_b, 8'h55);
      tick();
      check("ff_out_a", out_a, 8'hFF);
      check("ff_rise_a", rise_a, 8'h55);
      check("ff_fall_a", fall_a, 8'h00);

      data_in = 8'hFE;
      repeat (8) tick();
      check("fe_out_a", out_a, 8'hFE);

      pulses = 0;
      data_in = 8'hFF;
      repeat (2) begin tick(); pulses += int'(rise_a[0] | fall_a[0]); end
      data_in = 8'hFE;
      repeat (8) begin tick(); pulses += int'(rise_a[0] | fall_a[0]); end
      check("glitch2_pulses", 8'(pulses), 8'h00);
      check("glitch2_out", out_a, 8'hFE);

      rise_t = 0; fall_t = 0; rise_n = 0; fall_n = 0;
      data_in = 8'hFF;
      for (int t = 1; t <= 12; t++) begin
         tick();
         if (t == 3) data_in = 8'hFE;
         if (rise_a[0]) begin rise_n++; rise_t = t; end
         if (fall_a[0]) begin fall_n++; fall_t = t; end
      end
      check("pulse3_rise_t", 8'(rise_t), 8'd5);
      check("pulse3_fall_t", 8'(fall_t), 8'd8);
      check("pulse3_rise_n", 8'(rise_n), 8'd1);
      check("pulse3_fall_n", 8'(fall_n), 8'd1);

      pulses = 0;
      for (int t = 0; t < 12; t++) begin
         data_in = data_in ^ 8'h01;
         tick();
         pulses += int'(rise_a[0] | fall_a[0]);
      end
      data_in = 8'hFE;
      repeat (6) begin tick(); pulses += int'(rise_a[0] | fall_a[0]); end
      check("toggle_pulses", 8'(pulses), 8'h00);
      check("toggle_out", out_a, 8'hFE);

      data_in = 8'hFF;
      repeat (3) tick();
      #2 rst = 1'b1;
      #1;
      check("midrst_out_a", out_a, 8'h00);
      check("midrst_rise_a", rise_a, 8'h00);
      check("midrst_chg_a", {7'd0, chg_a}, 8'h00);
      check("midrst_out_b", out_b, 8'h00);
      @(posedge clk); #1 rst = 1'b0;
      repeat (4) tick();
      check("rel_out_a_e4", out_a, 8'h00);
      tick();
      check("rel_out_a", out_a, 8'hFF);
      check("rel_rise_a", rise_a, 8'hFF);
      check("rel_chg_a", {7'd0, chg_a}, 8'h01);

      data_in = 8'h00;
      repeat (3) tick();
      ena = 1'b0;
      tick();
      check("enadrop_pulse", rise_a | fall_a, 8'h00);
      check("enadrop_chg", {7'd0, chg_a}, 8'h00);
      ena = 1'b1;
      tick();
      check("enadrop_out_e5", out_a, 8'hFF);
      tick();
      check("enadrop_out_e6", out_a, 8'hFF);
      tick();
      check("enadrop_out_e7", out_a, 8'h00);
      check("enadrop_fall", fall_a, 8'hFF);

      repeat (3) tick();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
